aqp_clkrst_seq: RTL and testbench

- Sequences resets of the board-clock DCM (14.31818 MHz in, 28.63636 MHz out) and the downstream video PLL (25.175 MHz).
- Waits for each stage to lock, then holds and releases the system reset.
- Supervises lock while running: on loss of lock it re-runs the sequence from the stage that failed.
- Runs on the free-running oscillator clock and sits between the board clock input, the clock-control primitives and every reset consumer in the core.

---
 rtl/aqp_clkrst_seq.sv | 251 +++++++++++++++++++++++++
 tb/tb_aqp_clkrst_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/aqp_clkrst_seq.sv
// Clock/reset sequencer: DCM reset and lock, then PLL reset and lock, then a settle hold before sys_reset is released.
// Supervises lock while running; defining AQP_CLKRST_LOSS_CNT_EN adds a saturating lock-loss counter.
module aqp_clkrst_seq #(
  parameter int DCM_RST_CYCLES = 4,
  parameter int PLL_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dcm_locked,
  input  logic       dcm_clkin_stopped,
  input  logic       pll_locked,
`ifdef AQP_CLKRST_LOSS_CNT_EN
  input  logic       loss_cnt_clr,
  output logic [7:0] loss_cnt,
`endif
  output logic       dcm_rst,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt
);

  typedef enum logic [2:0] {
    ST_DCM_RST  = 3'd0,
    ST_DCM_WAIT = 3'd1,
    ST_PLL_RST  = 3'd2,
    ST_PLL_WAIT = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_RUN      = 3'd5,
    ST_FAIL     = 3'd6
  } state_t;

  // One shared counter, sized for the longest interval so a compare never sees a wrapped value.
  localparam int CNT_MAX_A = (DCM_RST_CYCLES > PLL_RST_CYCLES) ? DCM_RST_CYCLES : PLL_RST_CYCLES;
  localparam int CNT_MAX_B = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DCM_RST_LAST = CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       RETRY_LAST   = 3'(MAX_RETRIES - 1);
  localparam logic [2:0]       RETRY_SAT    = 3'(MAX_RETRIES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_retry_cnt;
  logic [1:0]       r_dl_sync;
  logic [1:0]       r_cs_sync;
  logic [1:0]       r_pl_sync;
  logic             r_dcm_bad_d;
  logic             r_pll_bad_d;
  logic             r_dcm_rst;
  logic             r_pll_rst;
  logic             r_sys_reset;
  logic             r_ready;
  logic             r_fail;

  logic w_dl;
  logic w_cs;
  logic w_pl;
  logic w_dcm_bad;
  logic w_pll_bad;
  logic w_dcm_loss;
  logic w_pll_loss;
  logic w_timeout;
  logic w_retry_last;
  logic w_fail_evt;
  logic w_dcm_rst_nxt;
  logic w_pll_rst_nxt;
  logic w_sys_reset_nxt;
  logic w_ready_nxt;
  logic w_fail_nxt;

  // Lock/status inputs come from other clock domains: two flops each before any decision.
  // NOTE: sequential state uses <= so every flop samples pre-edge values, as the hardware does.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_sync   <= '0;
      r_cs_sync   <= '0;
      r_pl_sync   <= '0;
      r_dcm_bad_d <= 1'b0;
      r_pll_bad_d <= 1'b0;
    end else begin
      r_dl_sync   <= {r_dl_sync[0], dcm_locked};
      r_cs_sync   <= {r_cs_sync[0], dcm_clkin_stopped};
      r_pl_sync   <= {r_pl_sync[0], pll_locked};
      r_dcm_bad_d <= w_dcm_bad;
      r_pll_bad_d <= w_pll_bad;
    end
  end

  assign w_dl         = r_dl_sync[1];
  assign w_cs         = r_cs_sync[1];
  assign w_pl         = r_pl_sync[1];
  assign w_dcm_bad    = !w_dl || w_cs;
  assign w_pll_bad    = !w_pl;
  // A loss must persist for two consecutive synchronised samples; single-cycle glitches are ignored.
  assign w_dcm_loss   = w_dcm_bad && r_dcm_bad_d;
  assign w_pll_loss   = w_pll_bad && r_pll_bad_d;
  assign w_timeout    = (r_cnt == TIMEOUT_LAST);
  assign w_retry_last = (r_retry_cnt == RETRY_LAST);

  // State register, shared counter, retry count and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_DCM_RST;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      r_dcm_rst   <= 1'b1;
      r_pll_rst   <= 1'b1;
      r_sys_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fail_evt) begin
        if (r_retry_cnt != RETRY_SAT) begin
          r_retry_cnt <= r_retry_cnt + 3'd1;
        end
      end else if ((w_state_nxt == ST_RUN) && (r_state != ST_RUN)) begin
        r_retry_cnt <= '0;
      end
      r_dcm_rst   <= w_dcm_rst_nxt;
      r_pll_rst   <= w_pll_rst_nxt;
      r_sys_reset <= w_sys_reset_nxt;
      r_ready     <= w_ready_nxt;
      r_fail      <= w_fail_nxt;
    end
  end

  // Next state. Priority inside each state: DCM loss, then PLL loss/lock, then count expiry.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_fail_evt  = 1'b0;
    case (r_state)
      ST_DCM_RST: begin
        if (r_cnt == DCM_RST_LAST) w_state_nxt = ST_DCM_WAIT;
      end
      ST_DCM_WAIT: begin
        if (w_dl && !w_cs) begin
          w_state_nxt = ST_PLL_RST;
        end else if (w_timeout) begin
          w_fail_evt  = 1'b1;
          w_state_nxt = w_retry_last ? ST_FAIL : ST_DCM_RST;
        end
      end
      ST_PLL_RST: begin
        if (r_cnt == PLL_RST_LAST) w_state_nxt = ST_PLL_WAIT;
      end
      ST_PLL_WAIT: begin
        if (w_dcm_loss) begin
          w_state_nxt = ST_DCM_RST;
        end else if (w_pl) begin
          w_state_nxt = ST_SETTLE;
        end else if (w_timeout) begin
          w_fail_evt  = 1'b1;
          w_state_nxt = w_retry_last ? ST_FAIL : ST_PLL_RST;
        end
      end
      ST_SETTLE: begin
        if (w_dcm_loss)                 w_state_nxt = ST_DCM_RST;
        else if (w_pll_loss)            w_state_nxt = ST_PLL_RST;
        else if (r_cnt == SETTLE_LAST)  w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_dcm_loss)      w_state_nxt = ST_DCM_RST;
        else if (w_pll_loss) w_state_nxt = ST_PLL_RST;
      end
      ST_FAIL: begin
        w_state_nxt = ST_FAIL;
      end
      default: begin
        w_state_nxt = ST_DCM_RST;
      end
    endcase
  end

  // Outputs decoded from the next state and registered, so they move with the state itself.
  always_comb begin
    w_dcm_rst_nxt   = 1'b1;
    w_pll_rst_nxt   = 1'b1;
    w_sys_reset_nxt = 1'b1;
    w_ready_nxt     = 1'b0;
    w_fail_nxt      = 1'b0;
    case (w_state_nxt)
      ST_DCM_WAIT: begin
        w_dcm_rst_nxt = 1'b0;
      end
      ST_PLL_RST: begin
        w_dcm_rst_nxt = 1'b0;
      end
      ST_PLL_WAIT, ST_SETTLE: begin
        w_dcm_rst_nxt = 1'b0;
        w_pll_rst_nxt = 1'b0;
      end
      ST_RUN: begin
        w_dcm_rst_nxt   = 1'b0;
        w_pll_rst_nxt   = 1'b0;
        w_sys_reset_nxt = 1'b0;
        w_ready_nxt     = 1'b1;
      end
      ST_FAIL: begin
        w_fail_nxt = 1'b1;
      end
      default: begin
        w_fail_nxt = 1'b0;
      end
    endcase
  end

  assign dcm_rst   = r_dcm_rst;
  assign pll_rst   = r_pll_rst;
  assign sys_reset = r_sys_reset;
  assign ready     = r_ready;
  assign fail      = r_fail;
  assign retry_cnt = r_retry_cnt;

`ifdef AQP_CLKRST_LOSS_CNT_EN
  logic       w_loss_evt;
  logic [7:0] r_loss_cnt;

  // Only losses that pull the core back out of SETTLE or RUN are counted.
  assign w_loss_evt = ((r_state == ST_SETTLE) || (r_state == ST_RUN)) && (w_dcm_loss || w_pll_loss);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_loss_cnt <= '0;
    end else if (loss_cnt_clr) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_aqp_clkrst_seq.sv
// Randomised bench for aqp_clkrst_seq: a reactive DCM/PLL environment drives the lock inputs and a
// cycle model built from the sequencing rules predicts every output; honours AQP_CLKRST_LOSS_CNT_EN.
module tb_aqp_clkrst_seq;

  localparam int DCM_RST_CYCLES = 4;
  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 32;
  localparam int SETTLE_CYCLES  = 8;
  localparam int MAX_RETRIES    = 3;
  localparam int N_CYCLES       = 12000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dcm_locked = 1'b0;
  logic       dcm_clkin_stopped = 1'b0;
  logic       pll_locked = 1'b0;
  logic       loss_clr = 1'b0;
  logic       dcm_rst, pll_rst, sys_reset, ready, fail;
  logic [2:0] retry_cnt;
`ifdef AQP_CLKRST_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  always #5 clk = ~clk;

  aqp_clkrst_seq #(
    .DCM_RST_CYCLES(DCM_RST_CYCLES),
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .dcm_locked       (dcm_locked),
    .dcm_clkin_stopped(dcm_clkin_stopped),
    .pll_locked       (pll_locked),
`ifdef AQP_CLKRST_LOSS_CNT_EN
    .loss_cnt_clr     (loss_clr),
    .loss_cnt         (loss_cnt),
`endif
    .dcm_rst          (dcm_rst),
    .pll_rst          (pll_rst),
    .sys_reset        (sys_reset),
    .ready            (ready),
    .fail             (fail),
    .retry_cnt        (retry_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {P_DCM_RST, P_DCM_WAIT, P_PLL_RST, P_PLL_WAIT, P_SETTLE, P_RUN, P_FAIL} phase_t;

  phase_t     m_phase;
  int         m_age;       // whole cycles spent in the current phase
  int         m_retry;
  int         m_loss;
  logic [2:0] m_hist[4];   // raw {dcm_locked, clkin_stopped, pll_locked} seen at the last 4 edges
  int         n_run_cycles, n_fail_cycles, n_run_loss;

  task automatic model_reset();
    m_phase = P_DCM_RST;
    m_age   = 0;
    m_retry = 0;
    m_loss  = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 3'b000;
  endtask

  function automatic bit dcm_bad(input logic [2:0] s);
    return !s[2] || s[1];
  endfunction

  // Advance the model across one rising edge that samples raw inputs `smp`.
  task automatic model_edge(input logic [2:0] smp, input logic clr);
    phase_t nxt;
    bit     dl, cs, pl, dloss, ploss, failure, lossev;
    phase_t fail_tgt;
    m_hist[3] = m_hist[2];
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = smp;
    // Decisions see the raw input two edges late; a loss needs that sample and the one before it.
    dl    = m_hist[2][2];
    cs    = m_hist[2][1];
    pl    = m_hist[2][0];
    dloss = dcm_bad(m_hist[2]) && dcm_bad(m_hist[3]);
    ploss = !m_hist[2][0] && !m_hist[3][0];
    nxt      = m_phase;
    failure  = 0;
    lossev   = 0;
    fail_tgt = P_DCM_RST;
    case (m_phase)
      P_DCM_RST:  if (m_age + 1 >= DCM_RST_CYCLES) nxt = P_DCM_WAIT;
      P_DCM_WAIT: begin
        if (dl && !cs) nxt = P_PLL_RST;
        else if (m_age + 1 >= LOCK_TIMEOUT) begin failure = 1; fail_tgt = P_DCM_RST; end
      end
      P_PLL_RST:  if (m_age + 1 >= PLL_RST_CYCLES) nxt = P_PLL_WAIT;
      P_PLL_WAIT: begin
        if (dloss) nxt = P_DCM_RST;
        else if (pl) nxt = P_SETTLE;
        else if (m_age + 1 >= LOCK_TIMEOUT) begin failure = 1; fail_tgt = P_PLL_RST; end
      end
      P_SETTLE, P_RUN: begin
        if (dloss)      begin nxt = P_DCM_RST; lossev = 1; end
        else if (ploss) begin nxt = P_PLL_RST; lossev = 1; end
        else if (m_phase == P_SETTLE && m_age + 1 >= SETTLE_CYCLES) nxt = P_RUN;
      end
      default: nxt = P_FAIL;
    endcase
    if (failure) begin
      nxt = (m_retry == MAX_RETRIES - 1) ? P_FAIL : fail_tgt;
      if (m_retry < MAX_RETRIES) m_retry++;
    end
    if (nxt == P_RUN && m_phase != P_RUN) m_retry = 0;
    if (lossev && m_phase == P_RUN) n_run_loss++;
    if (clr) m_loss = 0;
    else if (lossev && m_loss < 255) m_loss++;
    m_age   = (nxt != m_phase) ? 0 : m_age + 1;
    m_phase = nxt;
  endtask

  // Expected {dcm_rst, pll_rst, sys_reset, ready, fail} for a phase.
  function automatic logic [4:0] phase_outs(input phase_t p);
    logic d, pr;
    d  = (p == P_DCM_RST) || (p == P_FAIL);
    pr = d || (p == P_DCM_WAIT) || (p == P_PLL_RST);
    return {d, pr, (p != P_RUN), (p == P_RUN), (p == P_FAIL)};
  endfunction

  // ---------------- environment ----------------
  int dcm_delay, pll_delay, dcm_age, pll_age;
  int drop_d, drop_p, stop_cs;
  bit dead_dcm, dead_pll;
  int ep_len, ep_cnt;

  task automatic start_episode();
    dead_dcm = ($urandom_range(0, 5) == 0);
    dead_pll = ($urandom_range(0, 5) == 0);
    ep_len   = int'($urandom_range(150, 600));
    ep_cnt   = 0;
    drop_d   = 0;
    drop_p   = 0;
    stop_cs  = 0;
    dcm_age  = 0;
    pll_age  = 0;
  endtask

  // Behavioural DCM/PLL: lock after a random delay once released, with random lock drops.
  task automatic drive_inputs();
    if (dcm_rst) begin
      dcm_age   = 0;
      dcm_delay = dead_dcm ? 1 << 20 : int'($urandom_range(0, 40));
    end else dcm_age++;
    if (pll_rst) begin
      pll_age   = 0;
      pll_delay = dead_pll ? 1 << 20 : int'($urandom_range(0, 40));
    end else pll_age++;
    if (drop_d > 0) drop_d--;
    else if ($urandom_range(0, 79) == 0) drop_d = int'($urandom_range(1, 4));
    if (drop_p > 0) drop_p--;
    else if ($urandom_range(0, 79) == 0) drop_p = int'($urandom_range(1, 4));
    if (drop_d == 0 && drop_p == 0 && $urandom_range(0, 149) == 0) begin
      drop_d = int'($urandom_range(1, 3));
      drop_p = drop_d;
    end
    if (stop_cs > 0) stop_cs--;
    else if ($urandom_range(0, 299) == 0) stop_cs = int'($urandom_range(1, 3));
    dcm_locked        = (dcm_age >= dcm_delay) && (drop_d == 0);
    pll_locked        = (pll_age >= pll_delay) && (drop_p == 0);
    dcm_clkin_stopped = (stop_cs > 0);
    loss_clr          = ($urandom_range(0, 99) == 0);
  endtask

  logic [7:0] got_v, exp_v;

  initial begin
    n_run_cycles  = 0;
    n_fail_cycles = 0;
    n_run_loss    = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outs", {dcm_rst, pll_rst, sys_reset, ready, fail, retry_cnt}, {5'b11100, 3'd0});
`ifdef AQP_CLKRST_LOSS_CNT_EN
    check("reset_loss_cnt", loss_cnt, 0);
`endif
    start_episode();
    reset_n = 1'b1;
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      drive_inputs();
      model_edge({dcm_locked, dcm_clkin_stopped, pll_locked}, loss_clr);
      // Outputs are compared on the falling edge, half a cycle clear of the sampling edge.
      @(negedge clk);
      got_v = {dcm_rst, pll_rst, sys_reset, ready, fail, (m_phase == P_FAIL) ? 3'd0 : retry_cnt};
      exp_v = {phase_outs(m_phase), (m_phase == P_FAIL) ? 3'd0 : 3'(m_retry)};
      check("outs", 32'(got_v), 32'(exp_v));
`ifdef AQP_CLKRST_LOSS_CNT_EN
      check("loss_cnt", 32'(loss_cnt), 32'(m_loss));
`endif
      if (m_phase == P_RUN)  n_run_cycles++;
      if (m_phase == P_FAIL) n_fail_cycles++;
      ep_cnt++;
      if (ep_cnt >= ep_len) begin
        // Asynchronous reset between edges: outputs must return without any clock edge.
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_outs", {dcm_rst, pll_rst, sys_reset, ready, fail, retry_cnt}, {5'b11100, 3'd0});
`ifdef AQP_CLKRST_LOSS_CNT_EN
        check("async_rst_loss_cnt", loss_cnt, 0);
`endif
        model_reset();
        dcm_locked        = 1'b0;
        pll_locked        = 1'b0;
        dcm_clkin_stopped = 1'b0;
        @(negedge clk);
        start_episode();
        reset_n = 1'b1;
      end
    end
    check("reached_run", 32'(n_run_cycles > 0), 1);
    check("reached_fail", 32'(n_fail_cycles > 0), 1);
    check("saw_run_loss", 32'(n_run_loss > 0), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
